route_config_loader: RTL and testbench

Byte-stream configuration loader that sits directly upstream of the 8-channel signal router. It parses framed, checksummed write packets from a byte source such as the UART receiver. It drives the router's complete static configuration: RLoc, RSel, ClkDiv5..8, PWMRate5..8, C1..C4 and C5..C8. Payloads accumulate in a shadow register image, and a packet changes the router only after its checksum verifies; the whole packet then commits in one cycle, so the router never sees a half-written route.

---
 rtl/route_config_loader_if.sv | 10 +
 rtl/route_config_loader.sv | 202 ++++++++++++++++++++
 tb/tb_route_config_loader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/route_config_loader_if.sv
// Byte-stream handshake between a byte source (e.g. UART receiver) and the
// route configuration loader. A byte moves on a posedge with IN_VALID && IN_READY.
interface route_config_loader_if;
    logic [7:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;

    modport master (output IN_DATA, output IN_VALID, input IN_READY);
    modport slave  (input IN_DATA, input IN_VALID, output IN_READY);
endinterface

// File: rtl/route_config_loader.sv
// Framed, checksummed byte-stream loader for the 8-channel router's static
// configuration. Packet: A5, ADDR, LEN, LEN data bytes, CHK (XOR of ADDR, LEN
// and data). Data lands in a shadow image; the image is committed to the live
// outputs in a single cycle only once the checksum verifies.
module route_config_loader #(
    parameter int TIMEOUT = 1000000
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    route_config_loader_if.slave      in_bus,
    output logic [23:0]               RLoc,
    output logic [15:0]               RSel,
    output logic [25:0]               ClkDiv5,
    output logic [25:0]               ClkDiv6,
    output logic [25:0]               ClkDiv7,
    output logic [25:0]               ClkDiv8,
    output logic [7:0]                PWMRate5,
    output logic [7:0]                PWMRate6,
    output logic [7:0]                PWMRate7,
    output logic [7:0]                PWMRate8,
    output logic [7:0]                C1,
    output logic [7:0]                C2,
    output logic [7:0]                C3,
    output logic [7:0]                C4,
    output logic                      C5,
    output logic                      C6,
    output logic                      C7,
    output logic                      C8,
    output logic                      DONE,
    output logic                      ERR,
    output logic                      BUSY
);
    // Packed image holds only the bits the router uses (212 bits in total).
    localparam int IMG_W = 212;
    localparam int TW    = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_HUNT, S_ADDR, S_LEN, S_DATA, S_CHK, S_COMMIT} state_t;

    state_t             state, state_d;
    logic               ready_q, busy_q, done_q, err_q;
    logic [TW-1:0]      tmo_cnt;
    logic [IMG_W-1:0]   live, shadow;
    logic [7:0]         addr, rem, xsum;
    logic [4:0]         ptr;
    logic               accept, open, timeout, err_d, commit, len_bad;

    // Bit offset of a byte address inside the packed image; ClkDiv fields are
    // 26 bits wide, so each group of four bytes advances the offset by 26.
    function automatic int byte_off(input logic [4:0] a);
        int ai;
        ai = int'(a);
        if (ai < 5)
            return 8 * ai;
        else if (ai < 21)
            return 40 + 26 * ((ai - 5) / 4) + 8 * ((ai - 5) % 4);
        else
            return 144 + 8 * (ai - 21);
    endfunction

    // Bits of a byte address that are actually stored.
    function automatic logic [7:0] byte_mask(input logic [4:0] a);
        if (a == 5'd8 || a == 5'd12 || a == 5'd16 || a == 5'd20)
            return 8'h03;
        else if (a == 5'd29)
            return 8'h0F;
        else
            return 8'hFF;
    endfunction

    // Merge one byte into the image at its address, dropping unused bits.
    function automatic logic [IMG_W-1:0] put_byte(input logic [IMG_W-1:0] img,
                                                  input logic [4:0] a,
                                                  input logic [7:0] b);
        logic [7:0]       m;
        logic [IMG_W-1:0] wm, wd;
        m  = byte_mask(a);
        wm = IMG_W'(m) << byte_off(a);
        wd = IMG_W'(b & m) << byte_off(a);
        return (img & ~wm) | wd;
    endfunction

    assign accept  = in_bus.IN_VALID && ready_q;
    assign open    = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
    assign timeout = open && !accept && (tmo_cnt == TW'(TIMEOUT - 1));
    assign len_bad = (in_bus.IN_DATA == 8'd0) ||
                     (({1'b0, addr} + {1'b0, in_bus.IN_DATA}) > 9'd30);

    // Next-state decode of the packet parser; timeout overrides everything.
    always_comb begin
        state_d = state;
        err_d   = 1'b0;
        commit  = 1'b0;
        unique case (state)
            S_HUNT:   if (accept && in_bus.IN_DATA == 8'hA5) state_d = S_ADDR;
            S_ADDR:   if (accept) state_d = S_LEN;
            S_LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        state_d = S_HUNT;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA:   if (accept && rem == 8'd1) state_d = S_CHK;
            S_CHK: begin
                if (accept) begin
                    if (in_bus.IN_DATA == xsum) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_HUNT;
                        err_d   = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_HUNT;
                commit  = 1'b1;
            end
            default:  state_d = S_HUNT;
        endcase
        if (timeout) begin
            state_d = S_HUNT;
            err_d   = 1'b1;
        end
    end

    // Control state, registered status outputs, timeout counter and live image.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_HUNT;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
            live    <= '0;
        end else begin
            state   <= state_d;
            ready_q <= (state_d != S_COMMIT);
            busy_q  <= (state_d != S_HUNT);
            done_q  <= commit;
            err_q   <= err_d;
            if (!open || accept || timeout)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            if (commit)
                live <= shadow;
        end
    end

    // Packet datapath: header fields, running checksum and the shadow image.
    always_ff @(posedge CLK) begin
        if (accept) begin
            unique case (state)
                S_HUNT: if (in_bus.IN_DATA == 8'hA5) shadow <= live;
                S_ADDR: begin
                    addr <= in_bus.IN_DATA;
                    xsum <= in_bus.IN_DATA;
                end
                S_LEN: begin
                    xsum <= xsum ^ in_bus.IN_DATA;
                    ptr  <= addr[4:0];
                    rem  <= in_bus.IN_DATA;
                end
                S_DATA: begin
                    shadow <= put_byte(shadow, ptr, in_bus.IN_DATA);
                    xsum   <= xsum ^ in_bus.IN_DATA;
                    ptr    <= ptr + 1'b1;
                    rem    <= rem - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_bus.IN_READY = ready_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign BUSY     = busy_q;

    assign RLoc     = live[23:0];
    assign RSel     = live[39:24];
    assign ClkDiv5  = live[65:40];
    assign ClkDiv6  = live[91:66];
    assign ClkDiv7  = live[117:92];
    assign ClkDiv8  = live[143:118];
    assign PWMRate5 = live[151:144];
    assign PWMRate6 = live[159:152];
    assign PWMRate7 = live[167:160];
    assign PWMRate8 = live[175:168];
    assign C1       = live[183:176];
    assign C2       = live[191:184];
    assign C3       = live[199:192];
    assign C4       = live[207:200];
    assign C5       = live[208];
    assign C6       = live[209];
    assign C7       = live[210];
    assign C8       = live[211];
endmodule

// File: tb/tb_route_config_loader.sv
// Testbench for route_config_loader: directed packets, a packet-level model of
// the live register image, and a per-cycle compare of every output.
module tb_route_config_loader;
    localparam int TIMEOUT = 16;
    localparam int NF = 22;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    route_config_loader_if bus();

    logic [23:0] RLoc;
    logic [15:0] RSel;
    logic [25:0] ClkDiv5, ClkDiv6, ClkDiv7, ClkDiv8;
    logic [7:0]  PWMRate5, PWMRate6, PWMRate7, PWMRate8;
    logic [7:0]  C1, C2, C3, C4;
    logic        C5, C6, C7, C8;
    logic        DONE, ERR, BUSY;

    route_config_loader #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_bus(bus),
        .RLoc(RLoc), .RSel(RSel),
        .ClkDiv5(ClkDiv5), .ClkDiv6(ClkDiv6), .ClkDiv7(ClkDiv7), .ClkDiv8(ClkDiv8),
        .PWMRate5(PWMRate5), .PWMRate6(PWMRate6), .PWMRate7(PWMRate7), .PWMRate8(PWMRate8),
        .C1(C1), .C2(C2), .C3(C3), .C4(C4),
        .C5(C5), .C6(C6), .C7(C7), .C8(C8),
        .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_err = 0;

    // Model state: 30-byte register image plus the packet being collected.
    logic [7:0] m_img [0:29];
    logic [7:0] pkt [$];
    logic [7:0] tx [$];
    int         idle = 0;
    bit         m_commit = 1'b0, m_done = 1'b0, m_err = 1'b0;
    bit         m_ready = 1'b1, m_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mask_of(input int a);
        if (a == 8 || a == 12 || a == 16 || a == 20) return 8'h03;
        if (a == 29) return 8'h0F;
        return 8'hFF;
    endfunction

    function automatic logic [63:0] m_field(input int a, input int n);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < n; i++) r = r | (64'(m_img[a + i]) << (8 * i));
        return r;
    endfunction

    task automatic model_reset();
        foreach (m_img[i]) m_img[i] = 8'h00;
        pkt.delete();
        idle = 0;
        m_commit = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_ready = 1'b1; m_busy = 1'b0;
    endtask

    // One clock of the packet-level model.
    task automatic model_step();
        logic [7:0] x;
        int last;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_commit) begin
            for (int i = 0; i < int'(pkt[2]); i++)
                m_img[int'(pkt[1]) + i] = pkt[3 + i] & mask_of(int'(pkt[1]) + i);
            m_done = 1'b1;
            m_commit = 1'b0;
            m_ready = 1'b1;
            pkt.delete();
        end else if (bus.IN_VALID) begin
            idle = 0;
            if (pkt.size() == 0) begin
                if (bus.IN_DATA == 8'hA5) pkt.push_back(bus.IN_DATA);
            end else begin
                pkt.push_back(bus.IN_DATA);
                if (pkt.size() == 3) begin
                    if (pkt[2] == 8'd0 || int'(pkt[1]) + int'(pkt[2]) > 30) begin
                        m_err = 1'b1;
                        pkt.delete();
                    end
                end else if (pkt.size() > 3 && pkt.size() == int'(pkt[2]) + 4) begin
                    last = pkt.size() - 1;
                    x = 8'h00;
                    for (int i = 1; i < last; i++) x = x ^ pkt[i];
                    if (x == pkt[last]) begin
                        m_commit = 1'b1;
                        m_ready = 1'b0;
                    end else begin
                        m_err = 1'b1;
                        pkt.delete();
                    end
                end
            end
        end else if (pkt.size() != 0) begin
            idle++;
            if (idle == TIMEOUT) begin
                m_err = 1'b1;
                pkt.delete();
                idle = 0;
            end
        end
        m_busy = (pkt.size() != 0) || m_commit;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            if (!RST_N) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare of every DUT output against the model.
    initial begin
        string       names [NF];
        logic [63:0] act [NF];
        logic [63:0] exp [NF];
        names = '{"RLoc", "RSel", "ClkDiv5", "ClkDiv6", "ClkDiv7", "ClkDiv8",
                  "PWMRate5", "PWMRate6", "PWMRate7", "PWMRate8",
                  "C1", "C2", "C3", "C4", "C5", "C6", "C7", "C8",
                  "DONE", "ERR", "BUSY", "IN_READY"};
        forever begin
            @(negedge CLK);
            act = '{64'(RLoc), 64'(RSel), 64'(ClkDiv5), 64'(ClkDiv6), 64'(ClkDiv7), 64'(ClkDiv8),
                    64'(PWMRate5), 64'(PWMRate6), 64'(PWMRate7), 64'(PWMRate8),
                    64'(C1), 64'(C2), 64'(C3), 64'(C4), 64'(C5), 64'(C6), 64'(C7), 64'(C8),
                    64'(DONE), 64'(ERR), 64'(BUSY), 64'(bus.IN_READY)};
            if (!RST_N) begin
                foreach (exp[i]) exp[i] = 64'd0;
                exp[21] = 64'd1;
            end else begin
                exp[0] = m_field(0, 3);
                exp[1] = m_field(3, 2);
                exp[2] = m_field(5, 4);
                exp[3] = m_field(9, 4);
                exp[4] = m_field(13, 4);
                exp[5] = m_field(17, 4);
                for (int i = 0; i < 8; i++) exp[6 + i] = 64'(m_img[21 + i]);
                for (int i = 0; i < 4; i++) exp[14 + i] = 64'(m_img[29][i]);
                exp[18] = 64'(m_done);
                exp[19] = 64'(m_err);
                exp[20] = 64'(m_busy);
                exp[21] = 64'(m_ready);
                if (DONE) n_done++;
                if (ERR) n_err++;
            end
            for (int i = 0; i < NF; i++) check(names[i], act[i], exp[i]);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int   waited;
        logic took;
        waited = 0;
        bus.IN_DATA  = b;
        bus.IN_VALID = 1'b1;
        forever begin
            took = bus.IN_READY;
            @(posedge CLK);
            #1;
            if (took) break;
            waited++;
            if (waited > 8) begin
                n_errors++;
                $display("FAIL send_byte: IN_READY got 0 for %0d cycles, required 1", waited);
                break;
            end
        end
    endtask

    task automatic send_q();
        foreach (tx[i]) send_byte(tx[i]);
        bus.IN_VALID = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bus.IN_VALID = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation got no end by t=%0t, required earlier finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = 8'h00;
        RST_N = 1'b0;
        // Reset with the input toggling: nothing may be accepted.
        repeat (4) begin
            @(posedge CLK);
            #1;
            bus.IN_VALID = ~bus.IN_VALID;
            bus.IN_DATA  = 8'hA5;
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        bus.IN_VALID = 1'b0;
        idle_cycles(2);

        // Valid RLoc write.
        d0 = n_done; e0 = n_err;
        tx = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_q();
        idle_cycles(3);
        check("rloc_write", 64'(RLoc), 64'h332211);
        check("rloc_done_pulses", 64'(n_done - d0), 64'd1);
        check("rloc_err_pulses", 64'(n_err - e0), 64'd0);
        check("rloc_rsel_untouched", 64'(RSel), 64'h0);

        // Bad checksum.
        d0 = n_done; e0 = n_err;
        tx = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        send_q();
        idle_cycles(3);
        check("badchk_rloc_kept", 64'(RLoc), 64'h332211);
        check("badchk_err_pulses", 64'(n_err - e0), 64'd1);
        check("badchk_done_pulses", 64'(n_done - d0), 64'd0);

        // Width truncation, sent back to back.
        d0 = n_done;
        tx = {8'hA5, 8'h05, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01,
              8'hA5, 8'h1D, 8'h01, 8'hFF, 8'hE3};
        send_q();
        idle_cycles(3);
        check("clkdiv5_trunc", 64'(ClkDiv5), 64'h3FFFFFF);
        check("cbits_trunc", 64'({C8, C7, C6, C5}), 64'hF);
        check("trunc_done_pulses", 64'(n_done - d0), 64'd2);
        check("trunc_rloc_kept", 64'(RLoc), 64'h332211);

        // Range error, then garbage and a recovering packet.
        e0 = n_err;
        tx = {8'hA5, 8'h1C, 8'h03};
        send_q();
        check("range_busy_low", 64'(BUSY), 64'd0);
        idle_cycles(2);
        check("range_err_pulses", 64'(n_err - e0), 64'd1);
        d0 = n_done;
        tx = {8'h55, 8'hA5, 8'h03, 8'h02, 8'h0F, 8'hF0, 8'hFE};
        send_q();
        idle_cycles(3);
        check("rsel_write", 64'(RSel), 64'hF00F);
        check("rsel_done_pulses", 64'(n_done - d0), 64'd1);

        // LEN of zero is illegal.
        e0 = n_err;
        tx = {8'hA5, 8'h00, 8'h00};
        send_q();
        idle_cycles(2);
        check("len0_err_pulses", 64'(n_err - e0), 64'd1);

        // A5 inside the payload is ordinary data.
        tx = {8'hA5, 8'h19, 8'h02, 8'hA5, 8'h07, 8'hB9};
        send_q();
        idle_cycles(3);
        check("c1_a5_data", 64'(C1), 64'hA5);
        check("c2_data", 64'(C2), 64'h07);

        // Inter-byte timeout, then a normal packet.
        d0 = n_done; e0 = n_err;
        tx = {8'hA5, 8'h00};
        send_q();
        idle_cycles(TIMEOUT + 4);
        check("timeout_err_pulses", 64'(n_err - e0), 64'd1);
        check("timeout_busy_low", 64'(BUSY), 64'd0);
        check("timeout_rloc_kept", 64'(RLoc), 64'h332211);
        tx = {8'hA5, 8'h15, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h15};
        send_q();
        idle_cycles(3);
        check("pwm_after_timeout", 64'({PWMRate8, PWMRate7, PWMRate6, PWMRate5}), 64'h04030201);
        check("pwm_done_pulses", 64'(n_done - d0), 64'd1);

        // Reset in the middle of a packet.
        d0 = n_done; e0 = n_err;
        tx = {8'hA5, 8'h00, 8'h02, 8'h11};
        send_q();
        RST_N = 1'b0;
        idle_cycles(3);
        RST_N = 1'b1;
        idle_cycles(3);
        check("midrst_rloc_zero", 64'(RLoc), 64'h0);
        check("midrst_pwm_zero", 64'(PWMRate5), 64'h0);
        check("midrst_no_pulses", 64'((n_done - d0) + (n_err - e0)), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
